// File: rtl/xentry_pkg.sv
// Shared types for the L1/L2 request interface.
package xentry_pkg;

   typedef enum logic {
      LOAD  = 1'b0,
      STORE = 1'b1
   } memory_operation_e;

   typedef enum logic [1:0] {
      OWNER_NONE,
      OWNER_ICACHE,
      OWNER_DCACHE
   } l2_owner_e;

endpackage

// File: rtl/l2_request_arbiter.sv
// Round-robin owner of the single L2 request port; a grant lasts for a whole
// line transfer so fill beats from the two L1 caches never interleave.
module l2_request_arbiter
   import xentry_pkg::*;
#(
   parameter int LINE_SIZE = 16,
   parameter int XLEN      = 32
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [XLEN-1:0]   ic_req_address,
   input  memory_operation_e ic_req_type,
   input  logic              ic_req_valid,
   input  logic [XLEN-1:0]   ic_word_to_store,
   output logic [XLEN-1:0]   ic_fetched_word,
   output logic              ic_req_fulfilled,
   input  logic [XLEN-1:0]   dc_req_address,
   input  memory_operation_e dc_req_type,
   input  logic              dc_req_valid,
   input  logic [XLEN-1:0]   dc_word_to_store,
   output logic [XLEN-1:0]   dc_fetched_word,
   output logic              dc_req_fulfilled,
   output logic [XLEN-1:0]   l2_req_address,
   output memory_operation_e l2_req_type,
   output logic              l2_req_valid,
   output logic [XLEN-1:0]   l2_word_to_store,
   input  logic [XLEN-1:0]   l2_fetched_word,
   input  logic              l2_req_fulfilled
);

   localparam int BEATS_PER_LINE = LINE_SIZE / (XLEN / 8);
   localparam int CW             = $clog2(BEATS_PER_LINE) + 1;

   typedef enum logic [1:0] {
      IDLE,
      GRANT_IC,
      GRANT_DC
   } state_e;

   state_e    state_q;
   logic      prefer_dc_q;
   logic [CW-1:0] cnt_q;

   l2_owner_e owner;
   logic      own_vld, oth_vld, beat, line_done, release_grant;
   logic [CW-1:0] cnt_inc;

   always_comb begin
      case (state_q)
         GRANT_IC: owner = OWNER_ICACHE;
         GRANT_DC: owner = OWNER_DCACHE;
         default:  owner = OWNER_NONE;
      endcase
   end

   // Everything the port carries is steered by the registered owner only.
   always_comb begin
      l2_req_valid     = 1'b0;
      l2_req_address   = '0;
      l2_req_type      = LOAD;
      l2_word_to_store = '0;
      ic_fetched_word  = '0;
      ic_req_fulfilled = 1'b0;
      dc_fetched_word  = '0;
      dc_req_fulfilled = 1'b0;
      case (owner)
         OWNER_ICACHE: begin
            l2_req_valid     = ic_req_valid;
            l2_req_address   = ic_req_address;
            l2_req_type      = ic_req_type;
            l2_word_to_store = ic_word_to_store;
            ic_fetched_word  = l2_fetched_word;
            ic_req_fulfilled = l2_req_fulfilled;
         end
         OWNER_DCACHE: begin
            l2_req_valid     = dc_req_valid;
            l2_req_address   = dc_req_address;
            l2_req_type      = dc_req_type;
            l2_word_to_store = dc_word_to_store;
            dc_fetched_word  = l2_fetched_word;
            dc_req_fulfilled = l2_req_fulfilled;
         end
         default: ;
      endcase
   end

   assign own_vld       = (state_q == GRANT_IC) ? ic_req_valid : dc_req_valid;
   assign oth_vld       = (state_q == GRANT_IC) ? dc_req_valid : ic_req_valid;
   assign beat          = l2_req_valid & l2_req_fulfilled;
   assign cnt_inc       = cnt_q + CW'(beat);
   // The final beat closes the line in the same cycle it is fulfilled.
   assign line_done     = (cnt_inc == CW'(BEATS_PER_LINE));
   assign release_grant = !own_vld || line_done;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         prefer_dc_q <= 1'b1;
         cnt_q       <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               cnt_q <= '0;
               if (ic_req_valid && dc_req_valid)
                  state_q <= prefer_dc_q ? GRANT_DC : GRANT_IC;
               else if (dc_req_valid)
                  state_q <= GRANT_DC;
               else if (ic_req_valid)
                  state_q <= GRANT_IC;
            end
            GRANT_IC, GRANT_DC: begin
               if (release_grant) begin
                  prefer_dc_q <= (state_q == GRANT_IC);
                  cnt_q       <= '0;
                  if (oth_vld)
                     state_q <= (state_q == GRANT_IC) ? GRANT_DC : GRANT_IC;
                  else if (!own_vld)
                     state_q <= IDLE;
               end else begin
                  cnt_q <= cnt_inc;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule
